// File: rtl/audio_dac_serializer_if.sv
// Write-side bus of the audio DAC serializer: one stereo pair per accepted push.
`timescale 1ns/1ps
interface audio_dac_serializer_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata_left;
  logic [DATA_WIDTH-1:0] writedata_right;
  logic                  write_ready;

  modport master (
    output write, writedata_left, writedata_right,
    input  write_ready
  );

  modport slave (
    input  write, writedata_left, writedata_right,
    output write_ready
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// Stereo-pair FIFO feeding an I2S serializer clocked from CLOCK_50, with codec clocks synchronised in.
// Define AUDIO_DAC_UNDERFLOW_STATS_EN to build the saturating underflow frame counter.
`timescale 1ns/1ps
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  audio_dac_serializer_if.slave    bus,
  input  logic                     AUD_BCLK,
  input  logic                     AUD_DACLRCK,
  output logic                     AUD_DACDAT,
  output logic [15:0]              underflow_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    LEFT,
    RIGHT
  } state_e;

  // [0],[1] are the synchroniser stages, [2] is the previous synchronised value
  logic [2:0]            bclk_sync_q, bclk_sync_d;
  logic [2:0]            lrck_sync_q, lrck_sync_d;
  logic                  bclk_fall, lrck_fall, lrck_rise;

  logic [DATA_WIDTH-1:0] mem_left_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_right_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  dacdat_q, dacdat_d;

  assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lrck_fall = lrck_sync_q[2] & ~lrck_sync_q[1];
  assign lrck_rise = ~lrck_sync_q[2] & lrck_sync_q[1];

  assign bus.write_ready = (count_q != FULL_CNT);
  assign push            = bus.write && bus.write_ready;
  // Pop decision uses the registered count, so a same-cycle push into an empty FIFO is an underflow
  assign pop             = lrck_fall && (count_q != '0);

  assign AUD_DACDAT = dacdat_q;

  always_comb begin
    bclk_sync_d  = {bclk_sync_q[1:0], AUD_BCLK};
    lrck_sync_d  = {lrck_sync_q[1:0], AUD_DACLRCK};
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    shift_d      = shift_q;
    hold_right_d = hold_right_q;
    bit_cnt_d    = bit_cnt_q;
    dacdat_d     = dacdat_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // An LRCK edge restarts the slot; the BCLK fall that coincides with it still carries padding
    if (lrck_fall) begin
      state_d      = LEFT;
      shift_d      = pop ? mem_left_q[rd_ptr_q]  : '0;
      hold_right_d = pop ? mem_right_q[rd_ptr_q] : '0;
      bit_cnt_d    = '0;
      dacdat_d     = 1'b0;
    end else if (lrck_rise && (state_q == LEFT)) begin
      state_d   = RIGHT;
      shift_d   = hold_right_q;
      bit_cnt_d = '0;
      dacdat_d  = 1'b0;
    end else if (bclk_fall && (state_q != WAIT_SYNC)) begin
      if (bit_cnt_q != LAST_BIT) begin
        dacdat_d  = shift_q[DATA_WIDTH-1];
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= WAIT_SYNC;
      shift_q      <= '0;
      hold_right_q <= '0;
      bit_cnt_q    <= '0;
      dacdat_q     <= 1'b0;
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrck_sync_q  <= lrck_sync_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_right_q <= hold_right_d;
      bit_cnt_q    <= bit_cnt_d;
      dacdat_q     <= dacdat_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_left_q[wr_ptr_q]  <= bus.writedata_left;
      mem_right_q[wr_ptr_q] <= bus.writedata_right;
    end
  end

`ifdef AUDIO_DAC_UNDERFLOW_STATS_EN
  logic [15:0] underflow_q, underflow_d;

  always_comb begin
    underflow_d = underflow_q;
    if (lrck_fall && (count_q == '0) && (underflow_q != '1)) begin
      underflow_d = underflow_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= '0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign underflow_count = underflow_q;
`else
  assign underflow_count = '0;
`endif

endmodule

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, sample width per channel in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, stereo-pair FIFO entries; power of two, >= 2.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: port CLOCK_50 input 1, system clock.
REQ-004 SHALL have port reset_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port write input 1, push request for one stereo pair.
REQ-006 SHALL have port writedata_left input DATA_WIDTH, left sample (two's complement).
REQ-007 SHALL have port writedata_right input DATA_WIDTH, right sample.
REQ-008 SHALL have port write_ready output 1, FIFO not full.
REQ-009 SHALL have port AUD_BCLK input 1, codec bit clock, asynchronous to CLOCK_50.
REQ-010 SHALL have port AUD_DACLRCK input 1, codec frame clock: low = left, high = right.
REQ-011 SHALL have port AUD_DACDAT output 1, serial DAC data.
REQ-012 SHALL have port underflow_count output 16, saturating count of empty-FIFO frames.

Function
REQ-013 SHALL synchronise AUD_BCLK and AUD_DACLRCK through two flops each and derive single-cycle falling-edge pulses for BCLK and both-edge pulses for LRCK.
REQ-014 SHALL accept a push when write && write_ready; the pair is stored at the next CLOCK_50 edge; write while !write_ready is ignored with no side effect.
REQ-015 SHALL drive write_ready = (count != FIFO_DEPTH) from the registered occupancy count.
REQ-016 SHALL implement states WAIT_SYNC, LEFT, RIGHT: reset -> WAIT_SYNC; any state -> LEFT on LRCK falling edge; LEFT -> RIGHT on LRCK rising edge; RIGHT never returns to WAIT_SYNC.
REQ-017 SHALL pop on each LRCK falling edge when count != 0, loading left and right holding registers; when count == 0 SHALL load zeros into both and increment underflow_count.
REQ-018 SHALL, on simultaneous push and pop, leave count unchanged; a push into an empty FIFO in the same cycle as a pop SHALL NOT bypass and SHALL count as underflow.
REQ-019 SHALL, per channel, shift the holding word MSB-first: bit i is driven on the (i+1)th BCLK falling edge after the LRCK edge, giving the one-BCLK I2S delay.
REQ-020 SHALL drive AUD_DACDAT = 0 after DATA_WIDTH bits until the next LRCK edge, and 0 in WAIT_SYNC.
REQ-021 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-022 SHALL hold underflow_count at 16'hFFFF once reached.
REQ-023 SHALL register AUD_DACDAT on CLOCK_50; latency from synchronised BCLK falling edge to AUD_DACDAT change = 1 CLOCK_50 cycle after edge detection (3 cycles from pin).

Reset
REQ-024 SHALL on reset_n low asynchronously clear FIFO pointers and count, holding registers, shift counter, synchronisers and underflow_count, and force state WAIT_SYNC, AUD_DACDAT = 0, write_ready = 1.
REQ-025 SHALL discard any partially shifted word when reset asserts mid-frame; output resumes only after the next LRCK falling edge following release.

Configuration
REQ-026 SHALL compile the underflow counter only when macro AUDIO_DAC_UNDERFLOW_STATS_EN is defined; otherwise underflow_count SHALL be constant 0 and the counter logic absent, all other behaviour unchanged.

Verification
REQ-027 Reset, push L=24'hA5A5A5 R=24'h5A5A5A, run 32 BCLK/channel frames -> left slot serialises 101001011010010110100101 starting one BCLK after LRCK fall, right slot 010110100101101001011010, padding 0.
REQ-028 Push 8 pairs with no LRCK activity -> write_ready falls after 8th accepted push; 9th write ignored; after one LRCK falling edge write_ready = 1.
REQ-029 No pushes, 3 LRCK frames -> AUD_DACDAT stays 0, underflow_count = 3 (macro defined) / 0 (undefined).
REQ-030 With count = 1, assert write on the same cycle as LRCK-fall pop -> count stays 1, stored pair is the pushed one, next frame outputs it.
REQ-031 Assert reset_n low mid-left-word (bit 10) -> AUD_DACDAT = 0 immediately, FIFO empty, write_ready = 1; first output after release occurs only after a full LRCK falling edge.
